// File: rtl/data_memory_ctrl.sv
// Request/response data memory for the RV32I MEM stage: byte-lane stores, extended loads, fault flag.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them down.
module data_memory_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter                    INIT_FILE = ""
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_Req,
  output logic              o_Ready,
  input  logic              i_Wen,
  input  logic [1:0]        i_Size,
  input  logic              i_Unsigned,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [31:0]       i_Wd,
  output logic [31:0]       o_Rd,
  output logic              o_Valid,
  output logic              o_Fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              range_ok;
  logic              fault;
  logic              accept;
  logic              wr_en;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wdata;

  logic [31:0]       rword_q;
  logic              fault_q, load_q, uns_q;
  logic [1:0]        size_q, lane_q;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  // Subtraction wraps, so addresses below BASE_ADDR land far above DEPTH.
  always_comb begin
    off      = i_Addr - BASE_ADDR;
    idx      = off[IDX_W+1:2];
    range_ok = (off[ADDR_W-1:IDX_W+2] == '0);
`ifdef DMEM_MISALIGN_TRAP_EN
    fault    = !range_ok || (i_Size == 2'b11)
             || (i_Size == 2'b01 && i_Addr[0])
             || (i_Size == 2'b10 && i_Addr[1:0] != 2'b00);
`else
    fault    = !range_ok || (i_Size == 2'b11);
`endif
  end

  always_comb begin
    lane  = 2'b00;
    be    = 4'b0000;
    wdata = i_Wd;
    case (i_Size)
      2'b00: begin
        lane  = i_Addr[1:0];
        be    = 4'b0001 << i_Addr[1:0];
        wdata = {4{i_Wd[7:0]}};
      end
      2'b01: begin
        lane  = {i_Addr[1], 1'b0};
        be    = i_Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_Wd[15:0]}};
      end
      2'b10: begin
        lane  = 2'b00;
        be    = 4'b1111;
        wdata = i_Wd;
      end
      default: begin
        lane  = 2'b00;
        be    = 4'b0000;
        wdata = i_Wd;
      end
    endcase
  end

  assign accept = i_Req && (state_q == IDLE);
  assign wr_en  = accept && i_Wen && !fault;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_q <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
    end else if (accept) begin
      fault_q <= fault;
      load_q  <= !i_Wen;
      uns_q   <= i_Unsigned;
      size_q  <= i_Size;
      lane_q  <= lane;
    end
  end

  // Storage has no reset; response data is gated by state so o_Rd still clears asynchronously.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (accept) rword_q <= mem_q[idx];
  end

  always_comb begin
    o_Ready = (state_q == IDLE);
    o_Valid = (state_q == RESP);
    o_Fault = o_Valid && fault_q;
    o_Rd    = '0;
    rbyte   = rword_q[{lane_q, 3'b000} +: 8];
    rhalf   = rword_q[{lane_q[1], 4'b0000} +: 16];
    if (o_Valid && load_q && !fault_q) begin
      case (size_q)
        2'b00:   o_Rd = uns_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        2'b01:   o_Rd = uns_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        default: o_Rd = rword_q;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: driver queues expected responses, negedge monitor checks them.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        o_Ready, o_Valid, o_Fault;
  logic [31:0] o_Rd;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  data_memory_ctrl #(
    .ADDR_W   (32),
    .DEPTH    (1024),
    .BASE_ADDR(32'h0000_0000),
    .INIT_FILE("")
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_Req     (req),
    .o_Ready   (o_Ready),
    .i_Wen     (wen),
    .i_Size    (size),
    .i_Unsigned(uns),
    .i_Addr    (addr),
    .i_Wd      (wd),
    .o_Rd      (o_Rd),
    .o_Valid   (o_Valid),
    .o_Fault   (o_Fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_Valid) begin
      exp_t e;
      n_valid++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_Valid=1 with rd 0x%08h expected no response", o_Rd);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_rd"}, o_Rd, e.rd);
        chk({e.tag, "_fault"}, {31'h0, o_Fault}, {31'h0, e.fault});
        chk({e.tag, "_ready_low"}, {31'h0, o_Ready}, 32'h0);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!o_Ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!o_Ready) chk("ready_timeout", {31'h0, o_Ready}, 32'h1);
  endtask

  task automatic issue(input string tag, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_f, input bit push);
    exp_t e;
    wait_ready();
    wen  = w;
    size = s;
    uns  = u;
    addr = a;
    wd   = d;
    req  = 1'b1;
    if (push) begin
      e.tag   = tag;
      e.rd    = exp_rd;
      e.fault = exp_f;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  initial begin
    int v0;
    int k;
    #3;
    chk("rst_ready", {31'h0, o_Ready}, 32'h1);
    chk("rst_valid", {31'h0, o_Valid}, 32'h0);
    chk("rst_fault", {31'h0, o_Fault}, 32'h0);
    chk("rst_rd", o_Rd, 32'h0);
    #9 rst_n = 1'b1;

    issue("sw10",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
    issue("lw10",   0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);

    issue("sw20",   1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0,        0, 1);
    issue("sb21",   1, 2'b00, 0, 32'h21, 32'hFFFFFF80, 32'h0,        0, 1);
    issue("lb21",   0, 2'b00, 0, 32'h21, 32'h0,        32'hFFFFFF80, 0, 1);
    issue("lbu21",  0, 2'b00, 1, 32'h21, 32'h0,        32'h00000080, 0, 1);
    issue("lw20",   0, 2'b10, 0, 32'h20, 32'h0,        32'h11228044, 0, 1);

    issue("sw30",   1, 2'b10, 0, 32'h30, 32'hAABBCCDD, 32'h0,        0, 1);
    issue("sh32",   1, 2'b01, 0, 32'h32, 32'h12348001, 32'h0,        0, 1);
    issue("lh32",   0, 2'b01, 0, 32'h32, 32'h0,        32'hFFFF8001, 0, 1);
    issue("lhu32",  0, 2'b01, 1, 32'h32, 32'h0,        32'h00008001, 0, 1);
    issue("lw30",   0, 2'b10, 0, 32'h30, 32'h0,        32'h8001CCDD, 0, 1);
    issue("lwuns",  0, 2'b10, 1, 32'h30, 32'h0,        32'h8001CCDD, 0, 1);

    issue("swffc",  1, 2'b10, 0, 32'hFFC,  32'h55AA55AA, 32'h0, 0, 1);
    issue("lw_oor", 0, 2'b10, 0, 32'h1000, 32'h0,        32'h0, 1, 1);
    issue("sw_oor", 1, 2'b10, 0, 32'h1000, 32'h01020304, 32'h0, 1, 1);
    issue("lwffc",  0, 2'b10, 0, 32'hFFC,  32'h0,        32'h55AA55AA, 0, 1);
    issue("ld_sz3", 0, 2'b11, 0, 32'h10,   32'h0,        32'h0, 1, 1);
    issue("st_sz3", 1, 2'b11, 0, 32'h10,   32'h0BADF00D, 32'h0, 1, 1);
    issue("lw10b",  0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue("lw13",   0, 2'b10, 0, 32'h13,   32'h0,        32'h0, 1, 1);
    issue("lh33",   0, 2'b01, 0, 32'h33,   32'h0,        32'h0, 1, 1);
`else
    issue("lw13",   0, 2'b10, 0, 32'h13,   32'h0,        32'hDEADBEEF, 0, 1);
    issue("lh33",   0, 2'b01, 0, 32'h33,   32'h0,        32'hFFFF8001, 0, 1);
`endif

    // Held request: six edges from IDLE give exactly three accepts.
    wait_ready();
    wen = 0; size = 2'b10; uns = 0; addr = 32'h10; wd = '0;
    for (int i = 0; i < 3; i++) q.push_back('{tag: "held", rd: 32'hDEADBEEF, fault: 1'b0});
    v0  = n_valid;
    req = 1'b1;
    repeat (6) @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held_accepts", n_valid - v0, 32'd3);

    issue("rst_sw", 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0);
    chk("rst_sw_valid", {31'h0, o_Valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, o_Valid}, 32'h0);
    chk("arst_ready", {31'h0, o_Ready}, 32'h1);
    @(negedge clk) rst_n = 1'b1;

    issue("rst_lw", 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0);
    chk("rst_lw_rd_pre", o_Rd, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", o_Rd, 32'h0);
    chk("arst_valid2", {31'h0, o_Valid}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    issue("rst_flt", 0, 2'b10, 0, 32'h2000, 32'h0, 32'h0, 1, 0);
    chk("rst_flt_pre", {31'h0, o_Fault}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fault", {31'h0, o_Fault}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    issue("lw40", 0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1);

    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
